// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner and its debounce stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package keypad_pkg;

    // Scan sequencer: hold a row for its dwell time, then take one sample cycle
    typedef enum logic {
        DWELL  = 1'b0,
        SAMPLE = 1'b1
    } scanState_t;

    // Default key indices (row*COLS+col) for the game controls on a 4x4 pad
    localparam int DEF_LEFT_KEY  = 8;
    localparam int DEF_RIGHT_KEY = 12;
    localparam int DEF_FIRE_KEY  = 2;

    // Index width for n items, never narrower than one bit
    function automatic int calcKw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce: accepts a key candidate after DEB_FRAMES identical frames; KEYPAD_AUTOREPEAT_EN adds held-key repeats.
// Latency: evtNow/evtCode combinational in the frame-end cycle; key_code/key_valid/key_held one cycle after frame-end.
// Backpressure: none; events are single-cycle pulses that the consumer must take when presented.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int KW         = 4,
    parameter int DEB_FRAMES = 2
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    parameter int REPT_DELAY = 8,
    parameter int REPT_RATE  = 4
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frameEnd,
    input  logic          candPressed,
    input  logic [KW-1:0] candCode,
    output logic          evtNow,
    output logic [KW-1:0] evtCode,
    output logic [KW-1:0] key_code,
    output logic          key_valid,
    output logic          key_held
);

    localparam int DW = calcKw(DEB_FRAMES + 1);
    localparam logic [DW-1:0] DEB_N = DW'(DEB_FRAMES);

    logic          lastPressed;
    logic [KW-1:0] lastCode;
    logic [DW-1:0] runCnt;
    logic [DW-1:0] runNext;
    logic          sameCand;
    logic          stable;
    logic          acceptPress;
    logic          acceptNone;
    logic          reptNow;

    // Run length of identical frame candidates and the resulting accept decisions
    always_comb begin
        sameCand    = (candPressed == lastPressed) && (candCode == lastCode);
        runNext     = DW'(1);
        if (sameCand) begin
            runNext = (runCnt == DEB_N) ? runCnt : runCnt + 1'b1;
        end
        stable      = (runNext == DEB_N);
        // A stable press only fires when it differs from what is already accepted,
        // so rolling straight from one key to another still produces an event.
        acceptPress = frameEnd && stable && candPressed && (!key_held || (key_code != candCode));
        acceptNone  = frameEnd && stable && !candPressed && key_held;
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RCW = calcKw(((REPT_DELAY > REPT_RATE) ? REPT_DELAY : REPT_RATE) + 1);

    logic [RCW-1:0] reptCnt;
    logic [RCW-1:0] reptLimit;
    logic           reptFirst;

    // First repeat waits REPT_DELAY frames after acceptance, later ones REPT_RATE frames
    always_comb begin
        reptLimit = reptFirst ? RCW'(REPT_DELAY) : RCW'(REPT_RATE);
        reptNow   = frameEnd && key_held && !acceptPress && !acceptNone
                    && ((reptCnt + 1'b1) == reptLimit);
    end

    // Frames elapsed since the last generated event for the held key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reptCnt   <= '0;
            reptFirst <= 1'b1;
        end else if (acceptPress) begin
            reptCnt   <= '0;
            reptFirst <= 1'b1;
        end else if (reptNow) begin
            reptCnt   <= '0;
            reptFirst <= 1'b0;
        end else if (frameEnd && key_held) begin
            reptCnt   <= reptCnt + 1'b1;
        end
    end
`else
    // Single event per accepted press
    always_comb begin
        reptNow = 1'b0;
    end
`endif

    // Event request towards the game mapping, valid in the frame-end cycle
    always_comb begin
        evtNow  = acceptPress || reptNow;
        evtCode = acceptPress ? candCode : key_code;
    end

    // Candidate history and accepted key state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastPressed <= 1'b0;
            lastCode    <= '0;
            runCnt      <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid <= evtNow;
            if (evtNow) begin
                key_code <= evtCode;
            end
            if (frameEnd) begin
                lastPressed <= candPressed;
                lastCode    <= candCode;
                runCnt      <= runNext;
            end
            if (acceptPress) begin
                key_held <= 1'b1;
            end else if (acceptNone) begin
                key_held <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner with debounce and game mapping (player position, fire); KEYPAD_AUTOREPEAT_EN enables held-key repeat.
// Latency: key_valid/playPos/fire update one cycle after the frame-end sample (last row's SAMPLE cycle).
// Backpressure: none; key events are one-cycle pulses, the keypad itself cannot be stalled.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 2**21,
    parameter int DEB_FRAMES = 2,
    parameter int LEFT_KEY   = DEF_LEFT_KEY,
    parameter int RIGHT_KEY  = DEF_RIGHT_KEY,
    parameter int FIRE_KEY   = DEF_FIRE_KEY,
    parameter int POS_W      = 3,
    parameter int POS_MIN    = 1,
    parameter int POS_MAX    = 6,
    parameter int POS_INIT   = 1,
    parameter int REPT_DELAY = 8,
    parameter int REPT_RATE  = 4,
    localparam int KW        = calcKw(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [COLS-1:0]  keypadCol,
    output logic [ROWS-1:0]  keypadRow,
    output logic [KW-1:0]    key_code,
    output logic             key_valid,
    output logic             key_held,
    output logic [POS_W-1:0] playPos,
    output logic             fire
);

    localparam int NKEYS = ROWS * COLS;
    localparam int RW    = calcKw(ROWS);
    localparam int CW    = calcKw(SCAN_DIV);
    localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 2);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

    // The dwell phase needs at least one cycle; repeat timing must be non-zero
    if (SCAN_DIV < 2 || DEB_FRAMES < 1 || REPT_DELAY < 1 || REPT_RATE < 1) begin : gBadCfg
        $error("keypad_scan_ctrl: unsupported parameter values");
    end

    scanState_t     state;
    scanState_t     stateNext;
    logic           sampleNow;
    logic           frameEnd;
    logic [CW-1:0]  dwellCnt;
    logic [RW-1:0]  rowIdx;
    logic [NKEYS-1:0] snap;
    logic [NKEYS-1:0] frameBits;
    logic           candPressed;
    logic [KW-1:0]  candCode;
    logic           evtNow;
    logic [KW-1:0]  evtCode;

    // Scan state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DWELL;
        end else begin
            state <= stateNext;
        end
    end

    // Scan next-state: SCAN_DIV-1 dwell cycles, then a single sample cycle
    always_comb begin
        stateNext = state;
        sampleNow = 1'b0;
        case (state)
            DWELL: begin
                if (dwellCnt == DWELL_LAST) begin
                    stateNext = SAMPLE;
                end
            end
            SAMPLE: begin
                sampleNow = 1'b1;
                stateNext = DWELL;
            end
        endcase
    end

    assign frameEnd  = sampleNow && (rowIdx == ROW_LAST);
    assign keypadRow = ~(ROWS'(1) << rowIdx);

    // Live frame view: the row being sampled this cycle replaces its stale copy,
    // so the frame-end reduction sees the last row without an extra cycle.
    always_comb begin
        frameBits = snap;
        if (sampleNow) begin
            frameBits[int'(rowIdx) * COLS +: COLS] = ~keypadCol;
        end
    end

    // Dwell counter, row pointer and frame snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwellCnt <= '0;
            rowIdx   <= '0;
            snap     <= '0;
        end else begin
            if (state == DWELL) begin
                dwellCnt <= (dwellCnt == DWELL_LAST) ? '0 : dwellCnt + 1'b1;
            end else begin
                dwellCnt <= '0;
            end
            if (sampleNow) begin
                snap   <= frameBits;
                rowIdx <= (rowIdx == ROW_LAST) ? '0 : rowIdx + 1'b1;
            end
        end
    end

    // Reduce the frame to its lowest pressed index (multiple presses resolve low)
    always_comb begin
        candPressed = 1'b0;
        candCode    = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (frameBits[i]) begin
                candPressed = 1'b1;
                candCode    = KW'(i);
            end
        end
    end

    keypad_debounce #(
        .KW         (KW),
        .DEB_FRAMES (DEB_FRAMES)
`ifdef KEYPAD_AUTOREPEAT_EN
        ,
        .REPT_DELAY (REPT_DELAY),
        .REPT_RATE  (REPT_RATE)
`endif
    ) uDebounce (
        .clk         (clk),
        .rst         (rst),
        .frameEnd    (frameEnd),
        .candPressed (candPressed),
        .candCode    (candCode),
        .evtNow      (evtNow),
        .evtCode     (evtCode),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    // Game mapping: moves and fire land on the same edge that raises key_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            playPos <= POS_W'(POS_INIT);
            fire    <= 1'b0;
        end else begin
            fire <= evtNow && (evtCode == KW'(FIRE_KEY));
            if (evtNow) begin
                if ((evtCode == KW'(LEFT_KEY)) && (playPos != POS_W'(POS_MIN))) begin
                    playPos <= playPos - 1'b1;
                end else if ((evtCode == KW'(RIGHT_KEY)) && (playPos != POS_W'(POS_MAX))) begin
                    playPos <= playPos + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: randomized and directed key frames against a frame-level reference model.
// Latency checked: each expected event carries the cycle it must appear in.
// Backpressure: not applicable; a monitor pops expected events whenever key_valid is seen.
module tb_keypad_scan_ctrl;

    localparam int ROWS = 4, COLS = 4, NK = 16, SCAN_DIV = 4, DEB = 2, FRAME = 16;
    localparam int LEFT = 8, RIGHT = 12, FIREK = 2;
    localparam int PMIN = 1, PMAX = 6, PINIT = 1, RDELAY = 8, RRATE = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [COLS-1:0] keypadCol;
    logic [ROWS-1:0] keypadRow;
    logic [3:0]     key_code;
    logic           key_valid;
    logic           key_held;
    logic [2:0]     playPos;
    logic           fire;
    logic [NK-1:0]  keys = '0;

    int cyc;
    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        int cyc;
        int code;
        int pos;
    } evt_t;

    evt_t expQ[$];
    int   hist[$];
    bit   mHeld;
    int   mCode, mPos, sinceAcc, frameNo;

    keypad_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_FRAMES(DEB),
        .LEFT_KEY(LEFT), .RIGHT_KEY(RIGHT), .FIRE_KEY(FIREK),
        .POS_W(3), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT),
        .REPT_DELAY(RDELAY), .REPT_RATE(RRATE)
    ) dut (
        .clk(clk), .rst(rst), .keypadCol(keypadCol), .keypadRow(keypadRow),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
        .playPos(playPos), .fire(fire)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its column low while its row is driven
    always_comb begin
        keypadCol = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!keypadRow[r] && keys[r*COLS+c]) keypadCol[c] = 1'b0;
    end

    // Cycles since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nBad++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic logic [NK-1:0] keyMask(input int k);
        logic [NK-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Reference model: one call per frame with that frame's constant key mask
    task automatic modelFrame(input logic [NK-1:0] m);
        int c;
        bit stable;
        bit ev;
        c = -1;
        for (int i = NK - 1; i >= 0; i--) if (m[i]) c = i;
        hist.push_back(c);
        if (hist.size() > DEB) void'(hist.pop_front());
        stable = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != c) stable = 0;
        ev = 0;
        if (stable && c >= 0 && (!mHeld || mCode != c)) begin
            ev = 1; mHeld = 1; mCode = c; sinceAcc = 0;
        end else if (stable && c < 0) begin
            mHeld = 0;
        end else if (mHeld) begin
            sinceAcc++;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (sinceAcc >= RDELAY && (sinceAcc - RDELAY) % RRATE == 0) ev = 1;
`endif
        end
        if (ev) begin
            if (mCode == LEFT && mPos > PMIN) mPos--;
            else if (mCode == RIGHT && mPos < PMAX) mPos++;
            expQ.push_back('{FRAME * frameNo, mCode, mPos});
        end
    endtask

    task automatic modelReset();
        hist.delete();
        expQ.delete();
        mHeld = 0; mCode = 0; mPos = PINIT; sinceAcc = 0; frameNo = 0;
    endtask

    // Called on the negedge that opens a frame; leaves on the negedge that opens the next
    task automatic doFrame(input logic [NK-1:0] m);
        keys = m;
        frameNo++;
        modelFrame(m);
        repeat (FRAME) @(negedge clk);
        check("key_held", key_held, mHeld);
    endtask

    task automatic pressRelease(input int k);
        doFrame(keyMask(k)); doFrame(keyMask(k));
        doFrame('0); doFrame('0);
    endtask

    task automatic resetChecks();
        check("rst_keypadRow", keypadRow, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_held", key_held, 0);
        check("rst_key_code", key_code, 0);
        check("rst_fire", fire, 0);
        check("rst_playPos", playPos, PINIT);
    endtask

    // Monitor: row-drive sequence every cycle, scoreboard pop on every key_valid
    initial begin
        evt_t e;
        logic [3:0] expRow;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                expRow = ~(4'b0001 << ((cyc / SCAN_DIV) % ROWS));
                check("keypadRow", keypadRow, expRow);
                if (key_valid) begin
                    if (expQ.size() == 0) begin
                        nCmp++; nBad++;
                        $display("FAIL unexpected_event: key_code=%0d at cyc %0d, expected no event", key_code, cyc);
                    end else begin
                        e = expQ.pop_front();
                        check("event_cycle", cyc, e.cyc);
                        check("key_code", key_code, e.code);
                        check("fire", fire, (e.code == FIREK) ? 1 : 0);
                        check("playPos", playPos, e.pos);
                    end
                end else begin
                    check("fire_without_valid", fire, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NK-1:0] m;
        logic [NK-1:0] prev;
        modelReset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        resetChecks();
        rst = 1'b0;

        // Idle frames: rows cycle, no events
        doFrame('0); doFrame('0);
        check("playPos_idle", playPos, PINIT);

        // Fire key held three frames
        repeat (3) doFrame(keyMask(FIREK));
        doFrame('0); doFrame('0);

        // Right to the upper bound and beyond, then left to the lower bound
        for (int i = 0; i < 7; i++) pressRelease(RIGHT);
        check("playPos_max", playPos, PMAX);
        for (int i = 0; i < 7; i++) pressRelease(LEFT);
        check("playPos_min", playPos, PMIN);

        // Two keys resolve low, then roll to the remaining key
        doFrame(keyMask(5) | keyMask(9)); doFrame(keyMask(5) | keyMask(9));
        doFrame(keyMask(9)); doFrame(keyMask(9));
        doFrame('0); doFrame('0);

        // Bounce on alternate frames never settles
        for (int i = 0; i < 6; i++) doFrame((i % 2 == 0) ? keyMask(7) : '0);
        doFrame('0); doFrame('0);

        // Random frames, with frequent repeats of the previous mask so keys settle
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       m = '0;
                1:       m = keyMask($urandom_range(0, NK - 1));
                2:       m = keyMask($urandom_range(0, NK - 1)) | keyMask($urandom_range(0, NK - 1));
                default: m = prev;
            endcase
            doFrame(m);
            prev = m;
        end
        doFrame('0); doFrame('0);

        // Hold right (position leaves its reset value), then reset mid-frame
        repeat (3) doFrame(keyMask(RIGHT));
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        resetChecks();
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First event after reset needs two full frames
        repeat (3) doFrame(keyMask(RIGHT));
        doFrame('0); doFrame('0);

        // Back to the lower bound, then hold right for 20 frames
        for (int i = 0; i < 2; i++) pressRelease(LEFT);
        repeat (20) doFrame(keyMask(RIGHT));
        doFrame('0); doFrame('0);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("playPos_hold20", playPos, 5);
`else
        check("playPos_hold20", playPos, 2);
`endif

        check("pending_events", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
